// File: rtl/impl_window_checker.sv
// Multi-channel "trig |-> ##[MIN_DLY:MAX_DLY] cons" checker with pass/fail pulses and saturating counts.
// Ports: clk, rst_n, en, clr, trig_mode, ante, cons -> busy, pass/fail pulses and counts, fail_sticky,
// first_fail_ch, plus first_fail_time when CHK_FAIL_LOG_EN is defined.
module impl_window_checker #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 16,
  parameter int MIN_DLY = 0,
  parameter int MAX_DLY = 4,
  parameter int TS_W    = 32,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [2*NCH-1:0]     trig_mode,
  input  logic [NCH-1:0]       ante,
  input  logic [NCH-1:0]       cons,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       pass_pulse,
  output logic [NCH-1:0]       fail_pulse,
  output logic [NCH*CNT_W-1:0] pass_cnt,
  output logic [NCH*CNT_W-1:0] fail_cnt,
  output logic                 fail_sticky,
  output logic [CH_W-1:0]      first_fail_ch
`ifdef CHK_FAIL_LOG_EN
  ,
  output logic [TS_W-1:0]      first_fail_time
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_WIN  = 2'd2;

  localparam logic [7:0] KMIN = 8'(MIN_DLY);
  localparam logic [7:0] KMAX = 8'(MAX_DLY);

  logic [1:0] st_q [NCH];
  logic [1:0] st_d [NCH];
  logic [7:0] k_q  [NCH];
  logic [7:0] k_d  [NCH];

  logic [NCH-1:0]       prev_q;
  logic [NCH-1:0]       trig;
  logic [NCH-1:0]       freed;
  logic [NCH-1:0]       pa;
  logic [NCH-1:0]       pb;
  logic [NCH-1:0]       fl;
  logic [NCH*CNT_W-1:0] pc_d;
  logic [NCH*CNT_W-1:0] fc_d;
  logic [CNT_W:0]       psum;
  logic [CNT_W:0]       fsum;
  logic [CH_W-1:0]      ff_idx;
  logic                 det;

`ifdef CHK_FAIL_LOG_EN
  logic [TS_W-1:0] ts_q;
`endif

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      busy[i] = (st_q[i] != S_IDLE);
    end
  end

  // pa: attempt resolved as pass in WINDOW; pb: new attempt passing at k=0.
  // Both can fire together when MIN_DLY=0 and a back-to-back trigger sees cons=1.
  always_comb begin
    trig  = '0;
    freed = '0;
    pa    = '0;
    pb    = '0;
    fl    = '0;
    det   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      st_d[i] = st_q[i];
      k_d[i]  = k_q[i];
      unique case (trig_mode[2*i +: 2])
        2'b00:   det = ante[i];
        2'b01:   det = ante[i] & ~prev_q[i];
        2'b10:   det = ~ante[i] & prev_q[i];
        default: det = ante[i] ^ prev_q[i];
      endcase
      trig[i] = en & det;
      if (!en) begin
        st_d[i] = S_IDLE;
      end else begin
        freed[i] = (st_q[i] == S_IDLE);
        if (st_q[i] == S_WAIT) begin
          k_d[i] = k_q[i] + 8'd1;
          if (k_q[i] + 8'd1 == KMIN) st_d[i] = S_WIN;
        end else if (st_q[i] == S_WIN) begin
          if (cons[i]) begin
            pa[i]    = 1'b1;
            freed[i] = 1'b1;
            st_d[i]  = S_IDLE;
          end else if (k_q[i] == KMAX) begin
            fl[i]    = 1'b1;
            freed[i] = 1'b1;
            st_d[i]  = S_IDLE;
          end else begin
            k_d[i] = k_q[i] + 8'd1;
          end
        end
        if (freed[i] && trig[i]) begin
          if (MIN_DLY == 0 && cons[i]) begin
            pb[i] = 1'b1;
          end else if (MAX_DLY == 0) begin
            fl[i] = 1'b1;
          end else begin
            k_d[i]  = 8'd1;
            st_d[i] = (KMIN <= 8'd1) ? S_WIN : S_WAIT;
          end
        end
      end
    end
  end

  always_comb begin
    pc_d = pass_cnt;
    fc_d = fail_cnt;
    psum = '0;
    fsum = '0;
    for (int i = 0; i < NCH; i++) begin
      psum = {1'b0, pass_cnt[i*CNT_W +: CNT_W]}
           + (CNT_W+1)'(pa[i]) + (CNT_W+1)'(pb[i]);
      fsum = {1'b0, fail_cnt[i*CNT_W +: CNT_W]}
           + (CNT_W+1)'(fl[i]);
      pc_d[i*CNT_W +: CNT_W] = psum[CNT_W] ? '1 : psum[CNT_W-1:0];
      fc_d[i*CNT_W +: CNT_W] = fsum[CNT_W] ? '1 : fsum[CNT_W-1:0];
    end
  end

  always_comb begin
    ff_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (fl[i]) ff_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i] <= S_IDLE;
        k_q[i]  <= '0;
      end
      prev_q        <= '0;
      pass_pulse    <= '0;
      fail_pulse    <= '0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      fail_sticky   <= 1'b0;
      first_fail_ch <= '0;
`ifdef CHK_FAIL_LOG_EN
      ts_q            <= '0;
      first_fail_time <= '0;
`endif
    end else begin
      prev_q <= ante;
      if (clr) begin
        for (int i = 0; i < NCH; i++) begin
          st_q[i] <= S_IDLE;
          k_q[i]  <= '0;
        end
        pass_pulse    <= '0;
        fail_pulse    <= '0;
        pass_cnt      <= '0;
        fail_cnt      <= '0;
        fail_sticky   <= 1'b0;
        first_fail_ch <= '0;
`ifdef CHK_FAIL_LOG_EN
        ts_q            <= '0;
        first_fail_time <= '0;
`endif
      end else begin
        for (int i = 0; i < NCH; i++) begin
          st_q[i] <= st_d[i];
          k_q[i]  <= k_d[i];
        end
        pass_pulse <= pa | pb;
        fail_pulse <= fl;
        pass_cnt   <= pc_d;
        fail_cnt   <= fc_d;
        if (|fl && !fail_sticky) begin
          fail_sticky   <= 1'b1;
          first_fail_ch <= ff_idx;
`ifdef CHK_FAIL_LOG_EN
          first_fail_time <= ts_q;
`endif
        end
`ifdef CHK_FAIL_LOG_EN
        ts_q <= ts_q + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_impl_window_checker.sv
// Directed bench for impl_window_checker: a per-cycle vector table on a
// MIN=MAX=0 instance plus hand sequences on a MIN=1,MAX=3,CNT_W=4 instance.
module tb_impl_window_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  trig_mode = '0;
  logic [3:0]  ante = '0;
  logic [3:0]  cons = '0;

  logic [3:0]  a_busy, a_pp, a_fp, b_busy, b_pp, b_fp;
  logic [15:0] a_pc, a_fc, b_pc, b_fc;
  logic        a_fs, b_fs;
  logic [1:0]  a_ffc, b_ffc;
`ifdef CHK_FAIL_LOG_EN
  logic [31:0] a_fft, b_fft;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  impl_window_checker #(
    .NCH(4), .CNT_W(4), .MIN_DLY(1), .MAX_DLY(3), .TS_W(32)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .trig_mode(trig_mode), .ante(ante), .cons(cons),
    .busy(a_busy), .pass_pulse(a_pp), .fail_pulse(a_fp),
    .pass_cnt(a_pc), .fail_cnt(a_fc),
    .fail_sticky(a_fs), .first_fail_ch(a_ffc)
`ifdef CHK_FAIL_LOG_EN
    , .first_fail_time(a_fft)
`endif
  );

  impl_window_checker #(
    .NCH(4), .CNT_W(4), .MIN_DLY(0), .MAX_DLY(0), .TS_W(32)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .trig_mode(trig_mode), .ante(ante), .cons(cons),
    .busy(b_busy), .pass_pulse(b_pp), .fail_pulse(b_fp),
    .pass_cnt(b_pc), .fail_cnt(b_fc),
    .fail_sticky(b_fs), .first_fail_ch(b_ffc)
`ifdef CHK_FAIL_LOG_EN
    , .first_fail_time(b_fft)
`endif
  );

  typedef struct {
    logic [3:0] ante;
    logic [3:0] cons;
    logic [7:0] mode;
    logic       en;
    logic       clr;
    logic [3:0] ep;
    logic [3:0] ef;
    logic       es;
    logic [1:0] ech;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [3:0] a, input logic [3:0] c,
                      input logic [7:0] m, input logic e, input logic cl);
    ante = a;
    cons = c;
    trig_mode = m;
    en = e;
    clr = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{4'b0011, 4'b0001, 8'h00, 1'b1, 1'b0, 4'b0001, 4'b0010, 1'b1, 2'd1};
    tbl[1] = '{4'b0101, 4'b0100, 8'h00, 1'b1, 1'b0, 4'b0100, 4'b0001, 1'b1, 2'd1};
    tbl[2] = '{4'b0111, 4'b0010, 8'h55, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd1};
    tbl[3] = '{4'b0111, 4'b1111, 8'h55, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1};
    tbl[4] = '{4'b0001, 4'b0100, 8'hAA, 1'b1, 1'b0, 4'b0100, 4'b0010, 1'b1, 2'd1};
    tbl[5] = '{4'b1000, 4'b1000, 8'hFF, 1'b1, 1'b0, 4'b1000, 4'b0001, 1'b1, 2'd1};
    tbl[6] = '{4'b0011, 4'b0101, 8'hE4, 1'b1, 1'b0, 4'b0001, 4'b1010, 1'b1, 2'd1};
    tbl[7] = '{4'b1111, 4'b0000, 8'hE4, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1};
    tbl[8] = '{4'b1111, 4'b1111, 8'h00, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[9] = '{4'b1111, 4'b0000, 8'h00, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0};

    #12;
    chk("rst_busy", {a_busy, b_busy}, 0);
    chk("rst_cnt", {a_pc, a_fc, b_pc, b_fc}, 0);
    chk("rst_sticky", {a_fs, a_ffc, b_fs, b_ffc}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 8'h00, 1, 0);
    tick(0, 0, 8'h00, 1, 0);

    for (int r = 0; r < 10; r++) begin
      tick(tbl[r].ante, tbl[r].cons, tbl[r].mode, tbl[r].en, tbl[r].clr);
      chk($sformatf("tbl%0d_pass", r), b_pp, tbl[r].ep);
      chk($sformatf("tbl%0d_fail", r), b_fp, tbl[r].ef);
      chk($sformatf("tbl%0d_sticky", r), b_fs, tbl[r].es);
      chk($sformatf("tbl%0d_ffch", r), b_ffc, tbl[r].ech);
    end

    // overlapping level mode, three consecutive passes
    tick(0, 0, 8'h00, 1, 1);
    for (int n = 0; n < 3; n++) begin
      tick(4'b0001, 4'b0001, 8'h00, 1, 0);
      chk("lvl_pulse", b_pp[0], 1);
      chk("lvl_busy", b_busy[0], 0);
    end
    tick(0, 0, 8'h00, 1, 0);
    chk("lvl_cnt", b_pc[3:0], 3);
    chk("lvl_pulse_end", b_pp[0], 0);

    // rise trigger, pass at k=2
    tick(0, 0, 8'h55, 1, 1);
    tick(0, 0, 8'h55, 1, 0);
    tick(4'b0001, 0, 8'h55, 1, 0);
    chk("win_busy", a_busy, 4'b0001);
    tick(4'b0001, 0, 8'h55, 1, 0);
    chk("win_nopass", a_pp, 0);
    tick(4'b0001, 4'b0001, 8'h55, 1, 0);
    chk("win_pass", a_pp, 4'b0001);
    chk("win_pcnt", a_pc[3:0], 1);
    chk("win_idle", a_busy, 0);

    // rise trigger, cons only at k=0 (too early) -> fail at k=3
    tick(0, 0, 8'h55, 1, 0);
    tick(4'b0001, 4'b0001, 8'h55, 1, 0);
    tick(4'b0001, 0, 8'h55, 1, 0);
    tick(4'b0001, 0, 8'h55, 1, 0);
    chk("fail_early", a_fp, 0);
    chk("fail_busy", a_busy, 4'b0001);
    tick(4'b0001, 0, 8'h55, 1, 0);
    chk("fail_pulse", a_fp, 4'b0001);
    chk("fail_sticky", a_fs, 1);
    chk("fail_ffch", a_ffc, 0);
    chk("fail_cnt", a_fc[3:0], 1);

    // simultaneous fails on ch1/ch3, then a later ch0 fail
    tick(0, 0, 8'h55, 1, 1);
    for (int n = 0; n < 4; n++) tick(4'b1010, 0, 8'h55, 1, 0);
    chk("sim_fail", a_fp, 4'b1010);
    chk("sim_ffch", a_ffc, 1);
    for (int n = 0; n < 4; n++) tick(4'b1011, 0, 8'h55, 1, 0);
    chk("late_fail", a_fp, 4'b0001);
    chk("late_ffch", a_ffc, 1);
    chk("late_cnt", a_fc, 16'h1011);
    tick(0, 0, 8'h55, 1, 1);
    chk("clr_sticky", {a_fs, a_ffc}, 0);
    chk("clr_cnt", {a_pc, a_fc}, 0);

    // back-to-back passes on ch2 saturate the 4-bit counter
    tick(0, 0, 8'h00, 1, 1);
    for (int n = 0; n < 22; n++) begin
      tick(4'b0100, 4'b0100, 8'h00, 1, 0);
      if (n == 2) chk("b2b_cnt", a_pc[11:8], 2);
    end
    chk("sat_cnt", a_pc[11:8], 15);
    chk("sat_pulse", a_pp[2], 1);

    // either-edge: second edge inside the window is ignored
    tick(0, 0, 8'hC0, 1, 1);
    tick(4'b1000, 0, 8'hC0, 1, 0);
    tick(4'b0000, 0, 8'hC0, 1, 0);
    chk("edge_busy", a_busy[3], 1);
    tick(4'b0000, 4'b1000, 8'hC0, 1, 0);
    chk("edge_pass", a_pp, 4'b1000);
    tick(0, 0, 8'hC0, 1, 0);
    chk("edge_cnt", a_pc[15:12], 1);
    chk("edge_idle", {a_busy, a_pp}, 0);

    // async reset in the middle of a window
    tick(4'b0001, 0, 8'h55, 1, 0);
    chk("rstw_busy", a_busy[0], 1);
    rst_n = 1'b0;
    ante = 0;
    #1;
    chk("rstw_out", {a_busy, a_pp, a_fp}, 0);
    chk("rstw_cnt", a_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 4'b0001, 8'h55, 1, 0);
    chk("rstw_after", {a_busy, a_pp}, 0);

    // en drop mid-window aborts silently
    tick(4'b0001, 0, 8'h55, 1, 0);
    chk("en_busy", a_busy[0], 1);
    tick(4'b0001, 0, 8'h55, 0, 0);
    chk("en_abort", a_busy[0], 0);
    tick(4'b0001, 4'b0001, 8'h55, 1, 0);
    chk("en_nopulse", {a_pp, a_fp}, 0);
    chk("en_cnt", {a_pc, a_fc}, 0);

`ifdef CHK_FAIL_LOG_EN
    rst_n = 1'b0;
    ante = 0;
    cons = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 37; n++) tick(0, 0, 8'h00, 1, 0);
    tick(4'b0001, 0, 8'h00, 1, 0);
    chk("ts_first", b_fft, 37);
    tick(0, 0, 8'h00, 1, 0);
    tick(4'b0010, 0, 8'h00, 1, 0);
    chk("ts_hold", b_fft, 37);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
